// File: rtl/swervolf_pkg.sv
// Shared definitions for the GPIO input-conditioning block: register word
// offsets, the bus request bundle and small helpers.
package swervolf_pkg;

    localparam logic [2:0] GPIO_IN_RAW     = 3'd0;
    localparam logic [2:0] GPIO_IN_DEB     = 3'd1;
    localparam logic [2:0] GPIO_IN_IRQ_EN  = 3'd2;
    localparam logic [2:0] GPIO_IN_RISE_EN = 3'd3;
    localparam logic [2:0] GPIO_IN_FALL_EN = 3'd4;
    localparam logic [2:0] GPIO_IN_STATUS  = 3'd5;
    localparam logic [2:0] GPIO_IN_PERIOD  = 3'd6;
    localparam logic [2:0] GPIO_IN_INFO    = 3'd7;

    typedef struct packed {
        logic [4:0]  adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        logic        cyc;
        logic        stb;
    } gpio_wb_req_t;

    // Debounce counter width; counts 0..DB_SAMPLES-1.
    function automatic int cnt_w(input int db_samples);
        return (db_samples < 2) ? 1 : $clog2(db_samples);
    endfunction

    function automatic logic [31:0] byte_mask(input logic [3:0] sel);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{sel[b]}};
        return m;
    endfunction

endpackage

// File: rtl/swervolf_gpio_debounce.sv
// One input pin: 2-FF synchroniser, tick-driven debounce counter, debounced
// value and combinational rise/fall for the cycle the debounced value moves.
module swervolf_gpio_debounce
    import swervolf_pkg::*;
#(
    parameter int DB_SAMPLES = 3,
    parameter int CNT_W      = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pin,
    input  logic i_tick,
    input  logic i_bypass,
    output logic o_sync,
    output logic o_stable,
    output logic o_rise,
    output logic o_fall
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_SAMPLES - 1);

    logic             s1, s2, stable, nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    always_comb begin
        nxt     = stable;
        cnt_nxt = cnt;
        if (i_bypass) begin
            nxt     = s2;
            cnt_nxt = '0;
        end else if (i_tick) begin
            if (s2 == stable) begin
                cnt_nxt = '0;
            end else if (cnt == CNT_MAX) begin
                nxt     = s2;
                cnt_nxt = '0;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            s1     <= i_pin;
            s2     <= s1;
            stable <= nxt;
            cnt    <= cnt_nxt;
        end
    end

    assign o_sync   = s2;
    assign o_stable = stable;
    assign o_rise   = nxt & ~stable;
    assign o_fall   = ~nxt & stable;

endmodule

// File: rtl/swervolf_gpio_in.sv
// GPIO input conditioning: per-pin debounce, sticky edge status with
// level interrupt, shared debounce prescaler and a Wishbone register slave.
module swervolf_gpio_in
    import swervolf_pkg::*;
#(
    parameter int          WIDTH      = 32,
    parameter int          DB_SAMPLES = 3,
    parameter logic [15:0] PERIOD_RST = 16'd1000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_pins,
    output logic [WIDTH-1:0] o_gpio,
    output logic             o_irq,
    input  logic [4:0]       i_wb_adr,
    input  logic [31:0]      i_wb_dat,
    input  logic [3:0]       i_wb_sel,
    input  logic             i_wb_we,
    input  logic             i_wb_cyc,
    input  logic             i_wb_stb,
    output logic [31:0]      o_wb_rdt,
    output logic             o_wb_ack
);

    localparam int          CNT_W    = cnt_w(DB_SAMPLES);
    localparam logic [31:0] PIN_MASK = 32'((64'd1 << WIDTH) - 64'd1);
    localparam logic [31:0] INFO     = {8'(WIDTH), 4'(DB_SAMPLES), 20'd0};

    gpio_wb_req_t req;
    assign req = '{adr: i_wb_adr, dat: i_wb_dat, sel: i_wb_sel,
                   we: i_wb_we, cyc: i_wb_cyc, stb: i_wb_stb};

    logic             wr;
    logic [2:0]       wsel;
    logic [31:0]      bmask;
    logic [WIDTH-1:0] wm, wd, wclr;
    logic [15:0]      pm;
    logic [31:0]      rd_mux;

    logic [15:0]      presc, period;
    logic             tick, bypass;

    logic [WIDTH-1:0] sync_v, stable_v, rise_v, fall_v, set_v;
    logic [WIDTH-1:0] irq_en, rise_en, fall_en, status;

    logic unused_bits;
    assign unused_bits = &{1'b0, req.adr[1:0], req.dat};

    assign wr    = req.cyc & req.stb & req.we & ~o_wb_ack;
    assign wsel  = req.adr[4:2];
    assign bmask = byte_mask(req.sel) & PIN_MASK;
    assign wm    = bmask[WIDTH-1:0];
    assign wd    = req.dat[WIDTH-1:0];
    assign wclr  = (wr && wsel == GPIO_IN_STATUS) ? (wd & wm) : '0;
    assign pm    = {{8{req.sel[1]}}, {8{req.sel[0]}}};

    // period == 0 lets every pin follow its synchroniser directly.
    assign bypass = (period == 16'd0);
    assign tick   = !bypass && (presc == period);

    always_ff @(posedge i_clk) begin
        if (i_rst)
            presc <= '0;
        else if ((wr && wsel == GPIO_IN_PERIOD) || bypass || tick)
            presc <= '0;
        else
            presc <= presc + 16'd1;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        swervolf_gpio_debounce #(
            .DB_SAMPLES (DB_SAMPLES),
            .CNT_W      (CNT_W)
        ) u_db (
            .i_clk    (i_clk),
            .i_rst    (i_rst),
            .i_pin    (i_pins[i]),
            .i_tick   (tick),
            .i_bypass (bypass),
            .o_sync   (sync_v[i]),
            .o_stable (stable_v[i]),
            .o_rise   (rise_v[i]),
            .o_fall   (fall_v[i])
        );
    end

    assign o_gpio = stable_v;
    assign set_v  = (rise_v & rise_en) | (fall_v & fall_en);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            irq_en  <= '0;
            rise_en <= '0;
            fall_en <= '0;
            status  <= '0;
            period  <= PERIOD_RST;
            o_irq   <= 1'b0;
        end else begin
            if (wr && wsel == GPIO_IN_IRQ_EN)  irq_en  <= (irq_en  & ~wm) | (wd & wm);
            if (wr && wsel == GPIO_IN_RISE_EN) rise_en <= (rise_en & ~wm) | (wd & wm);
            if (wr && wsel == GPIO_IN_FALL_EN) fall_en <= (fall_en & ~wm) | (wd & wm);
            if (wr && wsel == GPIO_IN_PERIOD)  period  <= (period  & ~pm) | (req.dat[15:0] & pm);
            // A new edge on a bit wins over a clear of that bit in the same cycle.
            status <= (status & ~wclr) | set_v;
            o_irq  <= |(status & irq_en);
        end
    end

    always_comb begin
        rd_mux = 32'd0;
        case (wsel)
            GPIO_IN_RAW:     rd_mux = 32'(sync_v);
            GPIO_IN_DEB:     rd_mux = 32'(stable_v);
            GPIO_IN_IRQ_EN:  rd_mux = 32'(irq_en);
            GPIO_IN_RISE_EN: rd_mux = 32'(rise_en);
            GPIO_IN_FALL_EN: rd_mux = 32'(fall_en);
            GPIO_IN_STATUS:  rd_mux = 32'(status);
            GPIO_IN_PERIOD:  rd_mux = {16'd0, period};
            GPIO_IN_INFO:    rd_mux = INFO;
            default:         rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_wb_rdt <= 32'd0;
            o_wb_ack <= 1'b0;
        end else begin
            o_wb_rdt <= rd_mux;
            o_wb_ack <= req.cyc & ~o_wb_ack;
        end
    end

endmodule

// File: tb/tb_swervolf_gpio_in.sv
// Bench for swervolf_gpio_in: directed scenarios plus random pins/bus traffic
// checked every cycle against a behavioural model of the block.
module tb_swervolf_gpio_in;

    localparam int WIDTH = 32;
    localparam int DB    = 3;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic [WIDTH-1:0]  i_pins = '0;
    logic [WIDTH-1:0]  o_gpio;
    logic              o_irq;
    logic [4:0]        i_wb_adr = '0;
    logic [31:0]       i_wb_dat = '0;
    logic [3:0]        i_wb_sel = '0;
    logic              i_wb_we = 1'b0;
    logic              i_wb_cyc = 1'b0;
    logic              i_wb_stb = 1'b0;
    logic [31:0]       o_wb_rdt;
    logic              o_wb_ack;

    swervolf_gpio_in #(.WIDTH(WIDTH), .DB_SAMPLES(DB), .PERIOD_RST(16'd1000)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_pins   (i_pins),
        .o_gpio   (o_gpio),
        .o_irq    (o_irq),
        .i_wb_adr (i_wb_adr),
        .i_wb_dat (i_wb_dat),
        .i_wb_sel (i_wb_sel),
        .i_wb_we  (i_wb_we),
        .i_wb_cyc (i_wb_cyc),
        .i_wb_stb (i_wb_stb),
        .o_wb_rdt (o_wb_rdt),
        .o_wb_ack (o_wb_ack)
    );

    always #5 i_clk = ~i_clk;

    int errs = 0;
    int checks = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: each pin's debounced value flips once DB consecutive
    // prescaler ticks have seen the synchronised pin disagree with it.
    bit [31:0] m_s1, m_s2, m_deb, m_irq_en, m_rise, m_fall, m_status, m_rdt;
    int        m_run [32];
    bit [15:0] m_period;
    int        m_presc;
    bit        m_irq, m_ack;

    always @(posedge i_clk) begin : model
        bit [31:0] bm, set, clr, rv;
        bit        tick, wr, nd;
        int        a;
        if (i_rst) begin
            m_s1 = 0; m_s2 = 0; m_deb = 0; m_irq_en = 0; m_rise = 0; m_fall = 0;
            m_status = 0; m_rdt = 0; m_period = 16'd1000; m_presc = 0;
            m_irq = 0; m_ack = 0;
            for (int i = 0; i < 32; i++) m_run[i] = 0;
        end else begin
            a = int'(i_wb_adr[4:2]);
            case (a)
                0: rv = m_s2;
                1: rv = m_deb;
                2: rv = m_irq_en;
                3: rv = m_rise;
                4: rv = m_fall;
                5: rv = m_status;
                6: rv = {16'd0, m_period};
                default: rv = (WIDTH << 24) | (DB << 20);
            endcase
            for (int b = 0; b < 4; b++) bm[8*b +: 8] = {8{i_wb_sel[b]}};
            tick = (m_period != 0) && (m_presc == int'(m_period));
            wr   = i_wb_cyc && i_wb_stb && i_wb_we && !m_ack;
            set  = 0;
            for (int i = 0; i < 32; i++) begin
                nd = m_deb[i];
                if (m_period == 0) begin
                    nd = m_s2[i];
                    m_run[i] = 0;
                end else if (tick) begin
                    if (m_s2[i] != m_deb[i]) begin
                        m_run[i]++;
                        if (m_run[i] == DB) begin
                            nd = m_s2[i];
                            m_run[i] = 0;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
                if (nd && !m_deb[i] && m_rise[i]) set[i] = 1;
                if (!nd && m_deb[i] && m_fall[i]) set[i] = 1;
                m_deb[i] = nd;
            end
            m_s2 = m_s1;
            m_s1 = i_pins;
            clr = (wr && a == 5) ? (i_wb_dat & bm) : 32'd0;
            m_irq    = |(m_status & m_irq_en);
            m_status = (m_status & ~clr) | set;
            m_rdt    = rv;
            m_ack    = i_wb_cyc && !m_ack;
            if ((wr && a == 6) || m_period == 0 || tick) m_presc = 0;
            else m_presc++;
            if (wr) begin
                case (a)
                    2: m_irq_en = (m_irq_en & ~bm) | (i_wb_dat & bm);
                    3: m_rise   = (m_rise & ~bm) | (i_wb_dat & bm);
                    4: m_fall   = (m_fall & ~bm) | (i_wb_dat & bm);
                    6: m_period = (m_period & ~bm[15:0]) | (i_wb_dat[15:0] & bm[15:0]);
                    default: ;
                endcase
            end
        end
    end

    always @(negedge i_clk) begin
        if (mon_en) begin
            chk("mon_gpio", o_gpio, m_deb);
            chk("mon_irq", {31'd0, o_irq}, {31'd0, m_irq});
            chk("mon_ack", {31'd0, o_wb_ack}, {31'd0, m_ack});
            chk("mon_rdt", o_wb_rdt, m_rdt);
        end
    end

    task automatic wb_write(input logic [4:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        @(negedge i_clk);
        i_wb_adr = adr; i_wb_dat = dat; i_wb_sel = sel;
        i_wb_we = 1'b1; i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
        @(negedge i_clk);
        i_wb_we = 1'b0; i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    endtask

    task automatic wb_read(input logic [4:0] adr, output logic [31:0] dat);
        @(negedge i_clk);
        i_wb_adr = adr; i_wb_we = 1'b0; i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
        @(negedge i_clk);
        dat = o_wb_rdt;
        chk("rd_ack", {31'd0, o_wb_ack}, 32'd1);
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    endtask

    task automatic wb_read_chk(input string tag, input logic [4:0] adr, input logic [31:0] exp);
        logic [31:0] d;
        wb_read(adr, d);
        chk(tag, d, exp);
    endtask

    task automatic do_reset(input int n);
        @(negedge i_clk);
        i_rst = 1'b1;
        repeat (n) @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge i_clk);
        i_rst  = 1'b0;
        mon_en = 1'b1;

        // Reset state and identification
        chk("rst_gpio", o_gpio, 32'd0);
        chk("rst_irq", {31'd0, o_irq}, 32'd0);
        wb_read_chk("rst_period", 5'h18, 32'h0000_03E8);
        wb_read_chk("info", 5'h1C, 32'h2030_0000);

        // Bypass latency, interrupt and W1C
        wb_write(5'h18, 32'd0, 4'hF);
        wb_write(5'h0C, 32'h20, 4'hF);
        wb_write(5'h08, 32'h20, 4'hF);
        i_pins[5] = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        chk("byp_gpio_n1", {31'd0, o_gpio[5]}, 32'd0);
        @(negedge i_clk);
        chk("byp_gpio_n2", {31'd0, o_gpio[5]}, 32'd1);
        chk("byp_irq_n2", {31'd0, o_irq}, 32'd0);
        @(negedge i_clk);
        chk("byp_irq_n3", {31'd0, o_irq}, 32'd1);
        wb_read_chk("byp_status", 5'h14, 32'h20);
        wb_write(5'h14, 32'h20, 4'hF);
        chk("w1c_irq_hold", {31'd0, o_irq}, 32'd1);
        @(negedge i_clk);
        chk("w1c_irq_drop", {31'd0, o_irq}, 32'd0);
        wb_read_chk("w1c_status", 5'h14, 32'h0);

        // Debounced operation with period 4
        wb_write(5'h18, 32'd4, 4'hF);
        wb_write(5'h0C, 32'h1, 4'hF);
        i_pins[0] = 1'b1;
        repeat (10) @(negedge i_clk);
        i_pins[0] = 1'b0;
        repeat (30) @(negedge i_clk);
        chk("glitch_gpio", {31'd0, o_gpio[0]}, 32'd0);
        wb_read_chk("glitch_status", 5'h14, 32'h0);
        i_pins[0] = 1'b1;
        repeat (25) @(negedge i_clk);
        chk("hold_gpio", {31'd0, o_gpio[0]}, 32'd1);
        wb_read_chk("hold_status", 5'h14, 32'h1);
        wb_write(5'h14, 32'h1, 4'hF);

        // Falling-edge only
        wb_write(5'h18, 32'd0, 4'hF);
        wb_write(5'h0C, 32'h0, 4'hF);
        wb_write(5'h10, 32'h4, 4'hF);
        i_pins[2] = 1'b1;
        repeat (5) @(negedge i_clk);
        i_pins[2] = 1'b0;
        repeat (5) @(negedge i_clk);
        wb_read_chk("fall_status", 5'h14, 32'h4);
        wb_write(5'h14, 32'h4, 4'hF);
        i_pins[2] = 1'b1;
        repeat (5) @(negedge i_clk);
        wb_read_chk("norise_status", 5'h14, 32'h0);

        // Set beats a simultaneous clear
        wb_write(5'h10, 32'h0, 4'hF);
        wb_write(5'h0C, 32'h80, 4'hF);
        @(negedge i_clk);
        i_pins[7] = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        i_wb_adr = 5'h14; i_wb_dat = 32'h80; i_wb_sel = 4'hF;
        i_wb_we = 1'b1; i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
        @(negedge i_clk);
        i_wb_we = 1'b0; i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
        wb_read_chk("setwins_status", 5'h14, 32'h80);

        // Byte select
        wb_write(5'h08, 32'h0, 4'hF);
        wb_write(5'h08, 32'hFFFF_FFFF, 4'b0010);
        wb_read_chk("bytesel_irq_en", 5'h08, 32'h0000_FF00);

        // Reset in the middle of a debounce
        wb_write(5'h18, 32'd4, 4'hF);
        i_pins[1] = 1'b1;
        repeat (12) @(negedge i_clk);
        do_reset(2);
        chk("midrst_gpio", o_gpio, 32'd0);
        wb_read_chk("midrst_period", 5'h18, 32'h3E8);
        wb_write(5'h18, 32'd4, 4'hF);
        repeat (30) @(negedge i_clk);
        chk("restart_gpio", o_gpio, 32'h0000_00A7);

        // Random pins and bus traffic, checked by the monitor
        for (int it = 0; it < 500; it++) begin
            int r;
            logic [31:0] d;
            r = $urandom_range(0, 9);
            if (r <= 3) begin
                @(negedge i_clk);
                i_pins = i_pins ^ ($urandom & $urandom & $urandom);
            end else if (r == 4) begin
                int a;
                a = $urandom_range(2, 6);
                if (a == 6) wb_write(5'h18, $urandom_range(0, 3), 4'hF);
                else wb_write(5'(a * 4), $urandom, 4'($urandom));
            end else if (r == 5) begin
                wb_read(5'($urandom_range(0, 7) * 4), d);
            end else if (r == 6) begin
                wb_write(5'h14, $urandom, 4'($urandom));
            end else if (r == 7 && $urandom_range(0, 19) == 0) begin
                do_reset(1);
            end else begin
                repeat ($urandom_range(1, 6)) @(negedge i_clk);
            end
        end
        repeat (4) @(negedge i_clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
